gpr_file: RTL and testbench
===========================

GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each register in bits.
REQ-002 SHALL have parameter DEPTH, default 32: number of registers, range 2..256.
REQ-003 SHALL have parameter NUM_RD, default 2: number of independent read ports, range 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 0: when 1, register 0 reads as zero and ignores writes.
REQ-005 SHALL derive localparam AW = $clog2(DEPTH): address width.
REQ-006 SHALL have port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port i_we, input, 1: write enable.
REQ-009 SHALL have port i_waddr, input, AW: write address.
REQ-010 SHALL have port i_wdata, input, WIDTH: write data.
REQ-011 SHALL have port i_re, input, NUM_RD: per-port read enable.
REQ-012 SHALL have port i_raddr, input, NUM_RD*AW: read addresses; port k occupies bits [k*AW +: AW].
REQ-013 SHALL have port o_rdata, output, NUM_RD*WIDTH: read data; port k occupies bits [k*WIDTH +: WIDTH].
REQ-014 SHALL have port o_ready, output, 1: high when the clear sweep is done and the file accepts accesses.

Function
REQ-015 SHALL implement the FSM states CLEAR and RUN; i_rst forces CLEAR with sweep counter set to 0.
REQ-016 In CLEAR, SHALL write zero to register[counter] each cycle and increment counter; after writing DEPTH-1, SHALL enter RUN on the next edge (DEPTH cycles in CLEAR).
REQ-017 o_ready SHALL be a registered output: 0 in CLEAR, 1 in RUN.
REQ-018 In CLEAR, SHALL ignore i_we and i_re; o_rdata SHALL hold 0.
REQ-019 In RUN, with i_we=1, SHALL write i_wdata to register[i_waddr] at the clock edge.
REQ-020 Reads SHALL have 1-cycle latency: with i_re[k]=1 at edge N, o_rdata port k SHALL show register[i_raddr k] after edge N.
REQ-021 With i_re[k]=0, port k SHALL hold its previous o_rdata value.
REQ-022 When a read and a write target the same address in the same cycle, the read SHALL return i_wdata (write-first bypass); this applies to every port independently.
REQ-023 With ZERO_REG=1, writes to address 0 SHALL be ignored, reads of address 0 SHALL return 0, and no bypass SHALL occur for address 0.
REQ-024 Addresses >= DEPTH (non-power-of-two DEPTH) SHALL read as 0 and writes to them SHALL be ignored.
REQ-025 Multiple ports reading the same address in the same cycle SHALL all return identical data.

Reset
REQ-026 i_rst=1 at any edge, including mid-sweep or in RUN, SHALL restart CLEAR from counter 0, set o_ready=0 and o_rdata=0.
REQ-027 No register contents SHALL be relied on before the sweep completes; after it, every register SHALL read 0.
REQ-028 While i_rst is held, the sweep counter SHALL stay at 0; the sweep SHALL start on the first edge with i_rst=0.

Structure
REQ-029 FSM state encodings (CLEAR, RUN) SHALL be defined in shared package gpr_pkg.
REQ-030 The CLEAR/RUN FSM and sweep counter SHALL be a sub-module gpr_clear_fsm, which outputs the clear address, the clear write strobe, and ready.
REQ-031 Storage SHALL be a single WIDTH x DEPTH array named reg_gprs, so benches can probe it hierarchically.

Verification
REQ-032 Reset sweep: assert i_rst for 2 cycles, then release -> o_ready rises exactly 32 edges after release; all 32 entries read 0.
REQ-033 Write/read: write 0xDEADBEEF to r5, then read r5 on port 1 next cycle -> o_rdata port 1 = 0xDEADBEEF one edge later.
REQ-034 Bypass: write 0x12345678 to r7 while ports 0 and 1 both read r7 in the same cycle -> both ports show 0x12345678 after that edge.
REQ-035 ZERO_REG=1: write 0xFFFFFFFF to r0, then read r0 -> 0; same-cycle read r0 -> 0.
REQ-036 Mid-sweep reset: assert i_rst at sweep count 10 after r3 was written -> o_ready=0, full 32-cycle sweep restarts, r3 reads 0 afterwards.
REQ-037 DEPTH=24, NUM_RD=3: write 0xA5 to address 30 and read address 30 -> 0; writes and reads on 23 behave normally; i_re=0 holds the last data.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file: FSM state
// encoding and small helpers used by the clear sweep.
package gpr_pkg;

    // Register file lifecycle: CLEAR zeroes every entry, RUN serves accesses.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } gpr_state_e;

    // True when the sweep counter points at the last register of the file.
    function automatic logic sweep_last(input int cnt, input int depth);
        return cnt == (depth - 1);
    endfunction

endpackage

// File: rtl/gpr_file_if.sv
// Access bus of the register file: one write port, NUM_RD read ports and
// the ready indication. The master drives accesses, the slave answers.
interface gpr_file_if
    import gpr_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                    we;
    logic [AW-1:0]           waddr;
    logic [WIDTH-1:0]        wdata;
    logic [NUM_RD-1:0]       re;
    logic [NUM_RD*AW-1:0]    raddr;
    logic [NUM_RD*WIDTH-1:0] rdata;
    logic                    ready;

    modport master (
        output we,
        output waddr,
        output wdata,
        output re,
        output raddr,
        input  rdata,
        input  ready
    );

    modport slave (
        input  we,
        input  waddr,
        input  wdata,
        input  re,
        input  raddr,
        output rdata,
        output ready
    );

endinterface

// File: rtl/gpr_clear_fsm.sv
// CLEAR/RUN sequencer. After reset it walks every register address once,
// asserting a clear strobe, then raises ready and stays in RUN until the
// next reset. All outputs are registered.
module gpr_clear_fsm
    import gpr_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_clr_we,
    output logic          o_ready
);

    gpr_state_e    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_clr_we;
    logic          r_ready;

    // State, sweep counter and strobes advance together; reset parks the sweep at 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_CLEAR;
            r_cnt    <= '0;
            r_clr_we <= 1'b1;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (sweep_last(int'(r_cnt), DEPTH)) begin
                        r_state  <= ST_RUN;
                        r_cnt    <= '0;
                        r_clr_we <= 1'b0;
                        r_ready  <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        r_clr_we <= 1'b1;
                        r_ready  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_clr_we <= 1'b0;
                    r_ready  <= 1'b1;
                end
                default: begin
                    r_state  <= ST_CLEAR;
                    r_cnt    <= '0;
                    r_clr_we <= 1'b1;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_addr = r_cnt;
    assign o_clr_we   = r_clr_we;
    assign o_ready    = r_ready;

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file: one write port, NUM_RD registered read
// ports with write-first bypass, optional hard-wired zero register and a
// self-clearing sweep after every reset.
module gpr_file
    import gpr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [AW-1:0]           i_waddr,
    input  logic [WIDTH-1:0]        i_wdata,
    input  logic [NUM_RD-1:0]       i_re,
    input  logic [NUM_RD*AW-1:0]    i_raddr,
    output logic [NUM_RD*WIDTH-1:0] o_rdata,
    output logic                    o_ready
);

    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic        ZR_EN   = (ZERO_REG != 0);

    logic [WIDTH-1:0] reg_gprs [DEPTH];

    logic [AW-1:0] w_clr_addr;
    logic          w_clr_we;
    logic          w_ready;
    logic          w_waddr_ok;
    logic          w_wr_ok;

    gpr_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_clr_addr (w_clr_addr),
        .o_clr_we   (w_clr_we),
        .o_ready    (w_ready)
    );

    // A write is accepted only in RUN, inside the file, and never to a hard-wired zero.
    assign w_waddr_ok = ({1'b0, i_waddr} < DEPTH_L) && !(ZR_EN && (i_waddr == '0));
    assign w_wr_ok    = i_we && w_ready && !i_rst && w_waddr_ok;

    // Storage: the sweep owns the array while clearing, otherwise accepted writes land
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            reg_gprs[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            reg_gprs[i_waddr] <= i_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]    w_raddr;
        logic             w_rzero;
        logic [WIDTH-1:0] w_rd_val;
        logic [WIDTH-1:0] r_rdata_p1;

        assign w_raddr = i_raddr[k*AW +: AW];
        // Out-of-range addresses and the hard-wired zero read 0 and never bypass.
        assign w_rzero = ({1'b0, w_raddr} >= DEPTH_L) || (ZR_EN && (w_raddr == '0));

        // Read mux with write-first bypass of a same-cycle write to the same address
        always_comb begin
            w_rd_val = reg_gprs[w_raddr];
            if (w_rzero) begin
                w_rd_val = '0;
            end else if (w_wr_ok && (i_waddr == w_raddr)) begin
                w_rd_val = i_wdata;
            end
        end

        // Stage p1: read data register, zero outside RUN, holds when the port is idle
        always_ff @(posedge i_clk) begin
            if (i_rst || !w_ready) begin
                r_rdata_p1 <= '0;
            end else if (i_re[k]) begin
                r_rdata_p1 <= w_rd_val;
            end
        end

        assign o_rdata[k*WIDTH +: WIDTH] = r_rdata_p1;
    end

    assign o_ready = w_ready;

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: two instances (32 entries / 2 ports / no zero register
// and 24 entries / 3 ports / zero register) driven in lockstep, checked every
// cycle against an array-based reference model plus directed scenarios.
module tb_gpr_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        we    = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  re    = '0;
    logic [4:0]  raddr [3];

    gpr_file_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) bus_a ();
    gpr_file_if #(.WIDTH(32), .DEPTH(24), .NUM_RD(3)) bus_b ();

    assign bus_a.we    = we;
    assign bus_a.waddr = waddr;
    assign bus_a.wdata = wdata;
    assign bus_a.re    = re[1:0];
    assign bus_a.raddr = {raddr[1], raddr[0]};
    assign bus_b.we    = we;
    assign bus_b.waddr = waddr;
    assign bus_b.wdata = wdata;
    assign bus_b.re    = re;
    assign bus_b.raddr = {raddr[2], raddr[1], raddr[0]};

    gpr_file #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) dut_a (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (bus_a.we),
        .i_waddr (bus_a.waddr),
        .i_wdata (bus_a.wdata),
        .i_re    (bus_a.re),
        .i_raddr (bus_a.raddr),
        .o_rdata (bus_a.rdata),
        .o_ready (bus_a.ready)
    );

    gpr_file #(.WIDTH(32), .DEPTH(24), .NUM_RD(3), .ZERO_REG(1)) dut_b (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (bus_b.we),
        .i_waddr (bus_b.waddr),
        .i_wdata (bus_b.wdata),
        .i_re    (bus_b.re),
        .i_raddr (bus_b.raddr),
        .o_rdata (bus_b.rdata),
        .o_ready (bus_b.ready)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: index 0 = instance A, 1 = instance B.
    logic [31:0] m_mem   [2][32];
    logic [31:0] m_rd    [2][3];
    logic        m_ready [2];
    int          m_sweep [2];

    function automatic int dep(input int d);
        return (d == 0) ? 32 : 24;
    endfunction
    function automatic bit zr(input int d);
        return d != 0;
    endfunction
    function automatic int nrd(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_ready[d] = 1'b0;
                m_sweep[d] = 0;
                for (int k = 0; k < 3; k++) m_rd[d][k] = '0;
            end else if (!m_ready[d]) begin
                m_sweep[d]++;
                if (m_sweep[d] == dep(d)) begin
                    m_ready[d] = 1'b1;
                    for (int i = 0; i < 32; i++) m_mem[d][i] = '0;
                end
            end else begin
                bit wr_ok;
                int wa;
                wa    = int'(waddr);
                wr_ok = we && (wa < dep(d)) && !(zr(d) && wa == 0);
                for (int k = 0; k < nrd(d); k++) begin
                    int ra;
                    ra = int'(raddr[k]);
                    if (re[k]) begin
                        if (ra >= dep(d) || (zr(d) && ra == 0)) m_rd[d][k] = '0;
                        else if (wr_ok && wa == ra)             m_rd[d][k] = wdata;
                        else                                    m_rd[d][k] = m_mem[d][ra];
                    end
                end
                if (wr_ok) m_mem[d][wa] = wdata;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk_val("ready_a", 32'(bus_a.ready), 32'(m_ready[0]));
        chk_val("ready_b", 32'(bus_b.ready), 32'(m_ready[1]));
        for (int k = 0; k < 2; k++)
            chk_val($sformatf("rd_a_p%0d", k), bus_a.rdata[k*32 +: 32], m_rd[0][k]);
        for (int k = 0; k < 3; k++)
            chk_val($sformatf("rd_b_p%0d", k), bus_b.rdata[k*32 +: 32], m_rd[1][k]);
    endtask

    task automatic set_idle();
        we = 1'b0;
        re = '0;
        for (int k = 0; k < 3; k++) raddr[k] = '0;
    endtask

    task automatic set_raddr(input logic [4:0] a);
        for (int k = 0; k < 3; k++) raddr[k] = a;
    endtask

    // Releases reset and counts edges until each instance raises ready.
    task automatic sweep_count(input string tag, input int exp_a, input int exp_b);
        int n, rise_a, rise_b;
        rst = 1'b0;
        n = 0; rise_a = -1; rise_b = -1;
        while ((rise_a < 0 || rise_b < 0) && n < 100) begin
            step();
            n++;
            if (bus_a.ready && rise_a < 0) rise_a = n;
            if (bus_b.ready && rise_b < 0) rise_b = n;
        end
        chk_val({tag, "_a"}, rise_a, exp_a);
        chk_val({tag, "_b"}, rise_b, exp_b);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ready[d] = 1'b0;
            m_sweep[d] = 0;
            for (int k = 0; k < 3; k++) m_rd[d][k] = '0;
            for (int i = 0; i < 32; i++) m_mem[d][i] = '0;
        end
        set_idle();

        // Reset for two cycles, then time the sweep
        rst = 1'b1;
        step();
        step();
        chk_val("rst_ready_a", 32'(bus_a.ready), 32'h0);
        chk_val("rst_rdata_a", bus_a.rdata[31:0], 32'h0);
        sweep_count("sweep", 32, 24);

        // Every entry reads zero after the sweep
        for (int i = 0; i < 32; i++) begin
            re = 3'b111;
            set_raddr(5'(i));
            step();
            chk_val($sformatf("clr_a_%0d", i), bus_a.rdata[63:32], 32'h0);
            chk_val($sformatf("clr_b_%0d", i), bus_b.rdata[95:64], 32'h0);
        end
        set_idle();

        // Write r5, read it back on port 1 next cycle
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        we = 1'b0; re = 3'b010; raddr[1] = 5'd5;
        step();
        chk_val("wr_rd_a_p1", bus_a.rdata[63:32], 32'hDEADBEEF);
        chk_val("wr_rd_b_p1", bus_b.rdata[63:32], 32'hDEADBEEF);

        // Same-cycle write and read of r7 on all ports
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; re = 3'b111;
        set_raddr(5'd7);
        step();
        chk_val("byp_a_p0", bus_a.rdata[31:0],  32'h12345678);
        chk_val("byp_a_p1", bus_a.rdata[63:32], 32'h12345678);
        chk_val("byp_b_p2", bus_b.rdata[95:64], 32'h12345678);

        // r0: hard-wired zero in B, ordinary register in A
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re = 3'b111;
        set_raddr(5'd0);
        step();
        chk_val("zr_same_b", bus_b.rdata[31:0], 32'h0);
        chk_val("zr_same_a", bus_a.rdata[31:0], 32'hFFFFFFFF);
        we = 1'b0;
        step();
        chk_val("zr_later_b", bus_b.rdata[63:32], 32'h0);
        chk_val("zr_later_a", bus_a.rdata[63:32], 32'hFFFFFFFF);

        // Address 30 is outside B, inside A; address 23 is B's last entry
        we = 1'b1; waddr = 5'd30; wdata = 32'h000000A5; re = 3'b000;
        step();
        we = 1'b0; re = 3'b111; set_raddr(5'd30);
        step();
        chk_val("oor_b_p2", bus_b.rdata[95:64], 32'h0);
        chk_val("oor_a_p0", bus_a.rdata[31:0],  32'h000000A5);
        we = 1'b1; waddr = 5'd23; wdata = 32'h5A5A1234; re = 3'b000;
        step();
        we = 1'b0; re = 3'b100; raddr[2] = 5'd23;
        step();
        chk_val("last_b_p2", bus_b.rdata[95:64], 32'h5A5A1234);
        we = 1'b1; waddr = 5'd23; wdata = 32'h0BADF00D; re = 3'b000; set_raddr(5'd0);
        step();
        step();
        chk_val("hold_b_p2", bus_b.rdata[95:64], 32'h5A5A1234);
        set_idle();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            we    = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            re    = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                raddr[k] = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0) raddr[k] = waddr;
            end
            step();
        end
        rst = 1'b0;
        set_idle();
        for (int n = 0; n < 100 && !(m_ready[0] && m_ready[1]); n++) step();

        // Reset in RUN after writing r3, then a second reset at sweep count 10
        we = 1'b1; waddr = 5'd3; wdata = 32'h33333333;
        step();
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        chk_val("mid_ready_a", 32'(bus_a.ready), 32'h0);
        chk_val("mid_ready_b", 32'(bus_b.ready), 32'h0);
        sweep_count("resweep", 32, 24);
        re = 3'b111; set_raddr(5'd3);
        step();
        chk_val("r3_clr_a", bus_a.rdata[31:0], 32'h0);
        chk_val("r3_clr_b", bus_b.rdata[31:0], 32'h0);
        set_idle();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
